// File: rtl/game_pkg.sv
// Shared definitions for the score keeper: FSM state encoding, winner codes
// and BCD score widths.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } game_state_e;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_TEAM1 = 2'b01;
  localparam logic [1:0] WINNER_TEAM2 = 2'b10;

  localparam int BCD_W   = 4;          // one decimal digit
  localparam int BIN_W   = 7;          // binary score, 0..99
  localparam int BIN_MAX = 99;

  // Binary value of a two-digit BCD score (tens*10 + units).
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [2*BCD_W-1:0] bcd);
    return BIN_W'(32'(bcd[2*BCD_W-1:BCD_W]) * 32'd10 + 32'(bcd[BCD_W-1:0]));
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter with synchronous clear, saturating at 99.
// Also reports its binary value so the win check needs no BCD compare.
module bcd_counter2
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [2*BCD_W-1:0] bcd_o,
  output logic [BIN_W-1:0]   bin_o
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] units_q, units_d;
  logic             at_max;

  assign at_max = (tens_q == BCD_W'(9)) && (units_q == BCD_W'(9));

  // Next digit values: clear wins over increment; units wrap into tens.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc && !at_max) begin
      if (units_q == BCD_W'(9)) begin
        units_d = '0;
        tens_d  = tens_q + 1'b1;
      end else begin
        units_d = units_q + 1'b1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign bcd_o = {tens_q, units_q};
  assign bin_o = bcd_to_bin(bcd_o);

endmodule

// File: rtl/score_keeper.sv
// Score keeper: converts rising edges of the ball controller's goal flags
// into points, holds off after each goal, re-serves the ball and declares
// the winner once a team reaches WIN_SCORE. FSM state is visible on state_dbg.
module score_keeper
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int GOAL_HOLDOFF = 50_000_000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        score_to_team1,
  input  logic        score_to_team2,
  input  logic        start_n,
  output logic [7:0]  team1_score,
  output logic [7:0]  team2_score,
  output logic [1:0]  goal_flash,
  output logic        ball_reset,
  output logic        game_over,
  output logic [1:0]  winner,
  output game_state_e state_dbg
);

  localparam int               CNT_W     = (GOAL_HOLDOFF > 2) ? $clog2(GOAL_HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(GOAL_HOLDOFF - 1);
  localparam logic [BIN_W-1:0] WIN_BIN   = BIN_W'(WIN_SCORE);
  localparam logic [BIN_W-1:0] SAT_BIN   = BIN_W'(BIN_MAX);

  game_state_e          state_q, state_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [1:0]           flash_q, flash_d;
  logic [1:0]           winner_q, winner_d;
  logic                 ball_reset_q, ball_reset_d;
  logic                 flag1_q, flag2_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 start_prev_q;

  logic                 start_fall, goal1, goal2;
  logic                 clr_scores, inc1, inc2;
  logic [BIN_W-1:0]     bin1, bin2, next1, next2;

  assign start_fall = start_prev_q && !sync_q[SYNC_STAGES-1];
  assign goal1      = score_to_team1 && !flag1_q;
  assign goal2      = score_to_team2 && !flag2_q;
  assign next1      = (bin1 == SAT_BIN) ? bin1 : bin1 + 1'b1;
  assign next2      = (bin2 == SAT_BIN) ? bin2 : bin2 + 1'b1;

  // Start button synchroniser, falling-edge history and goal-flag history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      start_prev_q <= 1'b1;
      flag1_q      <= 1'b0;
      flag2_q      <= 1'b0;
    end else begin
      sync_q[0] <= start_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      start_prev_q <= sync_q[SYNC_STAGES-1];
      flag1_q      <= score_to_team1;
      flag2_q      <= score_to_team2;
    end
  end

  // Next state: a start press restarts the match from any state; goals are
  // only counted in PLAY; HOLD waits for the count and for both flags low.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    flash_d      = flash_q;
    winner_d     = winner_q;
    ball_reset_d = 1'b0;
    clr_scores   = 1'b0;
    inc1         = 1'b0;
    inc2         = 1'b0;
    if (start_fall) begin
      state_d      = PLAY;
      hold_cnt_d   = '0;
      flash_d      = 2'b00;
      winner_d     = WINNER_NONE;
      ball_reset_d = 1'b1;
      clr_scores   = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          if (goal1 && goal2) begin
            // Simultaneous goals are a wash: flash both, no point.
            flash_d    = 2'b11;
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else if (goal1) begin
            inc1    = 1'b1;
            flash_d = 2'b01;
            if (next1 == WIN_BIN) begin
              state_d  = OVER;
              winner_d = WINNER_TEAM1;
            end else begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_LOAD;
            end
          end else if (goal2) begin
            inc2    = 1'b1;
            flash_d = 2'b10;
            if (next2 == WIN_BIN) begin
              state_d  = OVER;
              winner_d = WINNER_TEAM2;
            end else begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end else if (!score_to_team1 && !score_to_team2) begin
            state_d      = PLAY;
            ball_reset_d = 1'b1;
            flash_d      = 2'b00;
          end
        end
        IDLE, OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      flash_q      <= 2'b00;
      winner_q     <= WINNER_NONE;
      ball_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      flash_q      <= flash_d;
      winner_q     <= winner_d;
      ball_reset_q <= ball_reset_d;
    end
  end

  bcd_counter2 u_team1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_scores),
    .inc   (inc1),
    .bcd_o (team1_score),
    .bin_o (bin1)
  );

  bcd_counter2 u_team2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_scores),
    .inc   (inc2),
    .bcd_o (team2_score),
    .bin_o (bin2)
  );

  assign goal_flash = flash_q;
  assign ball_reset = ball_reset_q;
  assign game_over  = (state_q == OVER);
  assign winner     = winner_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits directly downstream of the ball controller and consumes its score_to_team1 / score_to_team2 goal flags.
- Turns each goal event into exactly one point for the scoring team and holds off after each goal.
- Requests a ball re-serve and declares game over at a target score.
- Feeds the scoreboard/VGA overlay with two-digit BCD scores and a goal-flash indicator.

Parameters:
- WIN_SCORE, 7, points (binary, 1..99) at which a team wins; compared against the binary value of the BCD score.
- GOAL_HOLDOFF, 50_000_000, clk cycles spent in HOLD after a goal; all flags ignored during this time; minimum 2.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous start_n button input.

Ports:
- clk  in  1  system clock, same domain as the ball controller.
- rst_n  in  1  asynchronous active-low reset.
- score_to_team1  in  1  goal flag from the ball controller, level, may stay high for many cycles.
- score_to_team2  in  1  as above, for team 2.
- start_n  in  1  new-game push button, active-low, asynchronous.
- team1_score  out  8  BCD score, [7:4] tens, [3:0] units.
- team2_score  out  8  BCD score, same layout.
- goal_flash  out  2  one-hot scorer indicator, held for the whole of HOLD; bit0 = team1, bit1 = team2.
- ball_reset  out  1  single-cycle pulse: re-centre ball and serve.
- game_over  out  1  high while in OVER.
- winner  out  2  00 none, 01 team1, 10 team2; valid while game_over.

Behaviour:
- Reset (async assert, sync release): state IDLE; both scores 8'h00; goal_flash 0, ball_reset 0, game_over 0, winner 00; hold counter 0; flag edge registers 0; start synchroniser flops 1.
- Edge detect: flag_q registers each score flag every cycle. A goal event is flag high AND flag_q low.
- States: IDLE, PLAY, HOLD, OVER.
- IDLE → PLAY: on synchronised start_n falling edge.
  - Scores cleared; ball_reset pulses for exactly one cycle on the transition edge.
- PLAY, single team1 event at sample edge N:
  - team1_score increments at edge N, i.e. visible the cycle after the flag rises.
  - goal_flash = 01; enter HOLD with counter = GOAL_HOLDOFF-1.
  - Team2 events mirror this.
- PLAY, both flags rise in the same cycle: no point to either team; goal_flash = 11; HOLD is entered anyway.
- PLAY, flag already high on entry (no rising edge): no point is awarded.
- HOLD:
  - Counter decrements each cycle; all flags are ignored.
  - At counter 0 with both flags low: go to PLAY, pulse ball_reset for 1 cycle, clear goal_flash.
  - At counter 0 with a flag still high: wait in HOLD (counter stays 0) until both flags are low.
- Win check, performed in the same cycle as the increment:
  - If the new score equals WIN_SCORE, go to OVER instead of HOLD.
  - winner is set; game_over = 1; goal_flash is set as normal; no ball_reset.
- OVER: scores frozen. A start_n falling edge returns to PLAY exactly as from IDLE (scores cleared, ball_reset pulse, winner 00, game_over 0).
- start_n falling edge while in PLAY/HOLD: restart the match (same as IDLE → PLAY). Any pending hold is aborted.
- BCD arithmetic:
  - Units 9 → 0 with tens +1.
  - 99 saturates at 99 (relevant only if WIN_SCORE > 99 is misconfigured).
  - The binary compare uses tens*10 + units.
- rst_n asserted mid-HOLD or mid-pulse: immediate return to reset values; no ball_reset pulse is emitted on release.

Decomposition:
- Shared package (game_pkg): state encoding (IDLE=0, PLAY=1, HOLD=2, OVER=3), WINNER_NONE/TEAM1/TEAM2 constants, BCD digit width.
- Sub-module bcd_counter2:
  - Ports: clk, rst_n, clr, inc → 8-bit BCD output plus binary value.
  - Saturating at 99.
  - Instantiated once per team.

Test Plan:
1. Reset, then start_n low for 10 cycles → ball_reset one pulse only; scores 00/00; state PLAY.
2. GOAL_HOLDOFF=16; score_to_team1 high for 40 cycles → team1_score 8'h01 the cycle after the rise; goal_flash 01 throughout; ball_reset pulses once, on the first cycle after both the count expires and the flag falls.
3. Both flags rise together → scores unchanged 00/00; goal_flash 11; HOLD then re-serve.
4. WIN_SCORE=12; eleven team2 goals then a twelfth → team2_score 8'h12 (units wrap checked at 09→10); game_over 1; winner 10; no ball_reset; further flags ignored.
5. Team1 goal pulse during HOLD from a prior team2 goal → team1 score unchanged.
6. rst_n low mid-HOLD (counter 8) → all outputs at reset values immediately; no pulse after release; IDLE.
